// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: scans voices one per cycle, then grants a free voice, reuses a match or steals the oldest.
// Define VOICE_STEAL_EN to enable stealing with a key-off retrigger gap; otherwise a note-on with no free voice is dropped.

module voice_slot (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       panic,
  input  logic       grant,
  input  logic       steal,
  input  logic       rekey,
  input  logic       rel,
  input  logic       bump,
  input  logic [6:0] new_note,
  output logic       alloc,
  output logic       key,
  output logic [6:0] note,
  output logic [7:0] age
);
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      alloc <= 1'b0;
      key   <= 1'b0;
      note  <= '0;
      age   <= '0;
    end else if (panic) begin
      // pitch is kept so release tails stay in tune
      alloc <= 1'b0;
      key   <= 1'b0;
      age   <= '0;
    end else if (grant) begin
      alloc <= 1'b1;
      key   <= 1'b1;
      note  <= new_note;
      age   <= '0;
    end else if (steal) begin
      key  <= 1'b0;
      note <= new_note;
    end else if (rekey) begin
      key <= 1'b1;
      age <= '0;
    end else if (rel) begin
      alloc <= 1'b0;
      key   <= 1'b0;
    end else if (bump && alloc && age != 8'hff) begin
      age <= age + 8'd1;
    end
  end
endmodule

module voice_allocator #(
  parameter int NUM_VOICES    = 8,
  parameter int RETRIG_CYCLES = 2048
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    ev_valid,
  output logic                    ev_ready,
  input  logic                    ev_on,
  input  logic [6:0]              ev_note,
  input  logic                    all_off,
  output logic [7*NUM_VOICES-1:0] voice_freq,
  output logic [NUM_VOICES-1:0]   voice_key,
  output logic [4:0]              busy_count,
  output logic                    steal_pulse,
  output logic                    drop_pulse
);
  localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT, GAP} state_t;
  state_t state, state_nxt;

  logic [NUM_VOICES-1:0]      alloc, key, grant, steal, rekey, rel, bump, victim;
  logic [NUM_VOICES-1:0][6:0] note;
  logic [NUM_VOICES-1:0][7:0] age;
  logic [IW-1:0]              idx, m_idx, f_idx, o_idx;
  logic                       m_hit, f_hit, o_hit;
  logic [7:0]                 o_age;
  logic                       cap_on;
  logic [6:0]                 cap_note;
  logic                       accept, last, gap_done, drop;

  assign ev_ready = Reset_n && (state == IDLE) && !all_off;
  assign accept   = ev_valid && ev_ready;
  assign last     = (idx == IW'(NUM_VOICES - 1));

  always_ff @(posedge Clk) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (accept) state_nxt = SCAN;
      SCAN:   if (last) state_nxt = COMMIT;
      COMMIT: begin
        state_nxt = IDLE;
`ifdef VOICE_STEAL_EN
        if (cap_on && !m_hit && !f_hit) state_nxt = GAP;
`endif
      end
      GAP:    if (gap_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (all_off) state_nxt = IDLE;
  end

  // sequential scan: match / first free / oldest (strict > keeps lowest index on ties)
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      cap_on   <= 1'b0;
      cap_note <= '0;
      idx      <= '0;
      m_hit    <= 1'b0;
      f_hit    <= 1'b0;
      o_hit    <= 1'b0;
      m_idx    <= '0;
      f_idx    <= '0;
      o_idx    <= '0;
      o_age    <= '0;
    end else if (accept) begin
      cap_on   <= ev_on;
      cap_note <= ev_note;
      idx      <= '0;
      m_hit    <= 1'b0;
      f_hit    <= 1'b0;
      o_hit    <= 1'b0;
    end else if (state == SCAN && !all_off) begin
      idx <= idx + 1'b1;
      if (alloc[idx] && note[idx] == cap_note && !m_hit) begin
        m_hit <= 1'b1;
        m_idx <= idx;
      end
      if (!alloc[idx] && !f_hit) begin
        f_hit <= 1'b1;
        f_idx <= idx;
      end
      if (alloc[idx] && (!o_hit || age[idx] > o_age)) begin
        o_hit <= 1'b1;
        o_idx <= idx;
        o_age <= age[idx];
      end
    end
  end

  always_comb begin
    grant  = '0;
    rekey  = '0;
    rel    = '0;
    bump   = '0;
    victim = '0;
    if (state == COMMIT && !all_off) begin
      if (cap_on) begin
        if (m_hit) begin
          grant = '0;
        end else if (f_hit) begin
          grant[f_idx] = 1'b1;
          bump = ~(NUM_VOICES'(1) << f_idx);
        end else begin
          victim[o_idx] = 1'b1;
        end
      end else if (m_hit) begin
        rel[m_idx] = 1'b1;
      end
    end
`ifdef VOICE_STEAL_EN
    if (gap_done && !all_off) begin
      rekey[o_idx] = 1'b1;
      bump = ~(NUM_VOICES'(1) << o_idx);
    end
`endif
  end

`ifdef VOICE_STEAL_EN
  localparam int CW = $clog2(RETRIG_CYCLES + 1);
  logic [CW-1:0] gap_cnt;

  // counter is zero on entry to GAP, so key stays low for exactly RETRIG_CYCLES cycles
  always_ff @(posedge Clk) begin
    if (!Reset_n || state != GAP) gap_cnt <= '0;
    else                          gap_cnt <= gap_cnt + 1'b1;
  end

  assign gap_done = (state == GAP) && (gap_cnt == CW'(RETRIG_CYCLES - 1));
  assign steal    = victim;
  assign drop     = 1'b0;

  always_ff @(posedge Clk) begin
    if (!Reset_n) steal_pulse <= 1'b0;
    else          steal_pulse <= |steal;
  end
`else
  assign gap_done    = 1'b0;
  assign steal       = '0;
  assign drop        = |victim;
  assign steal_pulse = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (!Reset_n) drop_pulse <= 1'b0;
    else          drop_pulse <= drop;
  end

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
    voice_slot u_slot (
      .Clk      (Clk),
      .Reset_n  (Reset_n),
      .panic    (all_off),
      .grant    (grant[i]),
      .steal    (steal[i]),
      .rekey    (rekey[i]),
      .rel      (rel[i]),
      .bump     (bump[i]),
      .new_note (cap_note),
      .alloc    (alloc[i]),
      .key      (key[i]),
      .note     (note[i]),
      .age      (age[i])
    );
  end

  always_comb begin
    busy_count = '0;
    for (int i = 0; i < NUM_VOICES; i++) busy_count = busy_count + 5'(alloc[i]);
  end

  assign voice_key  = key;
  assign voice_freq = note;
endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: directed scenarios plus random note traffic against an array-based model.
module tb_voice_allocator;
  localparam int NV = 8;
  localparam int RC = 4;

  logic            Clk = 1'b0;
  logic            Reset_n = 1'b0;
  logic            ev_valid = 1'b0;
  logic            ev_on = 1'b0;
  logic [6:0]      ev_note = '0;
  logic            all_off = 1'b0;
  logic            ev_ready;
  logic [7*NV-1:0] voice_freq;
  logic [NV-1:0]   voice_key;
  logic [4:0]      busy_count;
  logic            steal_pulse, drop_pulse;

  always #5 Clk = ~Clk;

  voice_allocator #(.NUM_VOICES(NV), .RETRIG_CYCLES(RC)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_on(ev_on), .ev_note(ev_note), .all_off(all_off),
    .voice_freq(voice_freq), .voice_key(voice_key), .busy_count(busy_count),
    .steal_pulse(steal_pulse), .drop_pulse(drop_pulse)
  );

  int checks = 0, errors = 0;

  bit m_alloc[NV];
  bit m_key[NV];
  int m_note[NV];
  int m_age[NV];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NV-1:0] e_key();
    logic [NV-1:0] k;
    for (int i = 0; i < NV; i++) k[i] = m_key[i];
    return k;
  endfunction

  function automatic logic [7*NV-1:0] e_freq();
    logic [7*NV-1:0] f;
    for (int i = 0; i < NV; i++) f[7*i +: 7] = 7'(m_note[i]);
    return f;
  endfunction

  function automatic int e_busy();
    int b = 0;
    for (int i = 0; i < NV; i++) b += m_alloc[i];
    return b;
  endfunction

  task automatic m_touch(input int v);
    for (int j = 0; j < NV; j++)
      if (j != v && m_alloc[j] && m_age[j] < 255) m_age[j]++;
    m_age[v] = 0;
  endtask

  task automatic m_clear(input bit notes_too);
    for (int i = 0; i < NV; i++) begin
      m_alloc[i] = 0;
      m_key[i]   = 0;
      m_age[i]   = 0;
      if (notes_too) m_note[i] = 0;
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #2;
  endtask

  task automatic check_all(input string t);
    chk({t, "_key"}, voice_key, e_key());
    chk({t, "_freq"}, voice_freq, e_freq());
    chk({t, "_busy"}, busy_count, e_busy());
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!ev_ready && t < 200) begin
      cyc();
      t++;
    end
    chk("ev_ready_wait", ev_ready, 1);
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    ev_valid = 1'b0;
    all_off = 1'b0;
    cyc();
    m_clear(1);
    check_all("reset");
    chk("reset_ready", ev_ready, 0);
    chk("reset_pulses", {steal_pulse, drop_pulse}, 0);
    Reset_n = 1'b1;
    #1;
    chk("ready_after_reset", ev_ready, 1);
  endtask

  task automatic panic();
    all_off = 1'b1;
    #1;
    chk("ready_in_panic", ev_ready, 0);
    cyc();
    all_off = 1'b0;
    #1;
    m_clear(0);
    check_all("panic");
    chk("ready_after_panic", ev_ready, 1);
  endtask

  // abort_gap: GAP cycle (1..RC-1) at which all_off is raised, 0 for none
  task automatic send(input bit on, input int n, input int abort_gap);
    int match, free, old;
    bit stl, drp;
    wait_ready();
    ev_valid = 1'b1;
    ev_on = on;
    ev_note = 7'(n);
    cyc();
    ev_valid = 1'b0;
    match = -1; free = -1; old = -1;
    for (int i = 0; i < NV; i++) begin
      if (m_alloc[i] && m_note[i] == n && match < 0) match = i;
      if (!m_alloc[i] && free < 0) free = i;
      if (m_alloc[i] && (old < 0 || m_age[i] > m_age[old])) old = i;
    end
    repeat (NV) cyc();
    check_all("pre_commit");
    cyc();
    stl = 0; drp = 0;
    if (on && match < 0 && free >= 0) begin
      m_alloc[free] = 1; m_key[free] = 1; m_note[free] = n;
      m_touch(free);
    end else if (!on && match >= 0) begin
      m_alloc[match] = 0; m_key[match] = 0;
    end else if (on && match < 0) begin
`ifdef VOICE_STEAL_EN
      stl = 1;
      m_note[old] = n; m_key[old] = 0;
`else
      drp = 1;
`endif
    end
    check_all("commit");
    chk("steal_pulse", steal_pulse, stl);
    chk("drop_pulse", drop_pulse, drp);
    if (stl) begin
      for (int k = 1; k < RC; k++) begin
        if (k == abort_gap) begin
          panic();
          repeat (RC + 2) cyc();
          check_all("gap_abort_hold");
          return;
        end
        cyc();
        check_all("gap_low");
        chk("steal_once", steal_pulse, 0);
      end
      cyc();
      m_key[old] = 1;
      m_touch(old);
      check_all("gap_end");
      chk("ready_after_gap", ev_ready, 1);
    end else begin
      cyc();
      chk("pulses_clear", {steal_pulse, drop_pulse}, 0);
      chk("ready_after_commit", ev_ready, 1);
    end
  endtask

  task automatic abort_scan(input bit on, input int n, input int k, input bit use_reset);
    wait_ready();
    ev_valid = 1'b1;
    ev_on = on;
    ev_note = 7'(n);
    cyc();
    ev_valid = 1'b0;
    repeat (k) cyc();
    if (use_reset) begin
      do_reset();
    end else begin
      panic();
    end
    repeat (NV + 4) cyc();
    check_all("not_applied");
    chk("abort_pulses", {steal_pulse, drop_pulse}, 0);
  endtask

  initial begin
    m_clear(1);
    repeat (2) cyc();
    do_reset();

    // first note lands in voice 0 after NV+1 edges
    send(1, 60, 0);
    chk("first_key", voice_key, 8'h01);
    chk("first_freq0", voice_freq[6:0], 60);
    chk("first_busy", busy_count, 1);

    // release leaves a hole that the next note fills
    do_reset();
    send(1, 60, 0); send(1, 62, 0); send(1, 64, 0);
    send(0, 62, 0);
    chk("release_key", voice_key, 8'h05);
    chk("release_pitch", voice_freq[13:7], 62);
    send(1, 65, 0);
    chk("refill_key", voice_key, 8'h07);

    // repeated note-on is a no-op
    do_reset();
    send(1, 60, 0);
    send(1, 60, 0);
    chk("dup_busy", busy_count, 1);

    // full pool: steal oldest (voice 0) or drop
    do_reset();
    for (int i = 0; i < NV; i++) send(1, 60 + i, 0);
    send(1, 70, 0);
`ifdef VOICE_STEAL_EN
    chk("steal_freq0", voice_freq[6:0], 70);
    chk("steal_key", voice_key, 8'hff);
`else
    chk("drop_key", voice_key, 8'hff);
    chk("drop_freq0", voice_freq[6:0], 60);
`endif

    // panic during the gap (or while full, without stealing)
    do_reset();
    for (int i = 0; i < NV; i++) send(1, 60 + i, 0);
`ifdef VOICE_STEAL_EN
    send(1, 71, 2);
`else
    panic();
`endif
    chk("panic_busy", busy_count, 0);
    chk("panic_key", voice_key, 0);

    // reset and panic in the middle of a scan both lose the event
    do_reset();
    send(1, 60, 0);
    abort_scan(1, 62, 3, 1);
    send(1, 61, 0);
    abort_scan(1, 63, 2, 0);

    // random traffic on a small note range to force matches and a full pool
    do_reset();
    for (int it = 0; it < 250; it++) begin
      int r;
      r = $urandom_range(0, 24);
      if (r == 0) panic();
      else if (r == 1) abort_scan($urandom_range(0, 1) == 1, 60 + $urandom_range(0, 11), $urandom_range(0, NV - 1), 0);
      else send($urandom_range(0, 3) != 0, 60 + $urandom_range(0, 11),
                ($urandom_range(0, 7) == 0) ? $urandom_range(1, RC - 1) : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
